regex_cpu_ext: RTL and testbench
================================

# regex_cpu_ext

Parametrised next-generation regex thread executor. It accepts one thread (PC plus character-context ID), fetches that thread's instruction from program memory, and executes it against the current character of its context. It emits zero, one or two successor PCs, or an accept pulse. It sits between the thread scheduler (input/output PC handshakes) and the program memory arbiter. Beyond the base executor, it adds character ranges, wildcard, jump, two-way split and illegal-opcode reporting.

## Interface
- PC_WIDTH, 9, thread program-counter width
- CC_ID_BITS, 2, character-context ID width; 2**CC_ID_BITS contexts
- CHARACTER_WIDTH, 8, character width
- MEMORY_WIDTH, 20, instruction word: opcode [MEMORY_WIDTH-1 -: 4], operand [MEMORY_WIDTH-5:0]; requires MEMORY_WIDTH-4 ≥ max(2*CHARACTER_WIDTH, PC_WIDTH)
- MEMORY_ADDR_WIDTH, 11, program memory address width; requires ≥ PC_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- current_characters  in  (2**CC_ID_BITS)*CHARACTER_WIDTH  character of context k at [k*CHARACTER_WIDTH +: CHARACTER_WIDTH]
- end_of_string  in  2**CC_ID_BITS  context k has reached end of string
- input_pc_valid / input_pc_ready  in / out  1  thread input handshake
- input_cc_id  in  CC_ID_BITS  context of incoming thread
- input_pc  in  PC_WIDTH  PC of incoming thread
- memory_valid  out  1  instruction fetch request
- memory_addr  out  MEMORY_ADDR_WIDTH  fetch address, PC zero-extended
- memory_ready  in  1  fetch response; memory_data valid in the same cycle
- memory_data  in  MEMORY_WIDTH  instruction word
- output_pc_valid / output_pc_ready  out / in  1  successor thread handshake
- output_pc  out  PC_WIDTH  successor PC
- output_cc_id  out  CC_ID_BITS  successor context, always equal to the executing thread's cc_id
- accepts  out  1  one-cycle pulse: thread accepted
- illegal_opcode  out  1  one-cycle pulse: undefined opcode executed

## Operation
- States: IDLE, FETCH, EXEC, OUT1, OUT2.
- IDLE: input_pc_ready=1.
  - On valid&&ready, latch pc and cc_id, then go to FETCH.
- FETCH: memory_valid=1, memory_addr={0,pc}.
  - On memory_ready, latch memory_data and go to EXEC.
  - Addr and valid stay stable until memory_ready.
- EXEC: one cycle. Sample ch = current_characters[cc_id], eos = end_of_string[cc_id]; lo = operand[CHARACTER_WIDTH-1:0], hi = operand[2*CHARACTER_WIDTH-1:CHARACTER_WIDTH], tgt = operand[PC_WIDTH-1:0].
  - 0 ACCEPT: if eos, pulse accepts; thread dies either way. Go to IDLE.
  - 1 SPLIT: OUT1 with pc+1, then OUT2 with tgt.
  - 2 MATCH: survive iff ch==lo.
  - 3 NOT_MATCH: survive iff ch!=lo.
  - 4 MATCH_ANY: always survive.
  - 5 JMP: OUT1 with tgt.
  - 6 RANGE: survive iff lo≤ch≤hi, unsigned compare.
  - 7 NOT_RANGE: survive iff ch<lo or ch>hi. If lo>hi, RANGE never survives and NOT_RANGE always survives.
  - 8-15: pulse illegal_opcode, thread dies, go to IDLE.
  - Character ops (2,3,4,6,7) with eos=1: thread dies.
  - Survive → OUT1 with pc+1; die → IDLE.
- pc+1 and PC arithmetic wrap modulo 2**PC_WIDTH: 2**PC_WIDTH-1 → 0.
- OUT1/OUT2: output_pc_valid=1; output_pc and output_cc_id are held stable until output_pc_ready.
  - OUT1 transfer → OUT2 if SPLIT, else IDLE.
  - OUT2 transfer → IDLE.
- Exactly one thread in flight; input_pc_ready=0 outside IDLE.

## Timing
- Reset: state IDLE. memory_valid, output_pc_valid, accepts and illegal_opcode are 0. input_pc_ready=0 while rst=1 and 1 the first cycle after rst falls. Latched registers clear to 0.
- Reset in any state aborts the thread with no output or pulse. A memory_ready arriving during reset is ignored.
- Latency, with input accepted at edge 0 and zero-wait memory (memory_ready high in first FETCH cycle):
  - memory_valid high in cycle 1.
  - EXEC in cycle 2.
  - output_pc_valid (or accepts/illegal_opcode pulse) in cycle 3.
- input_pc_ready returns in cycle 3 for a dying thread, and the cycle after the last output transfer otherwise.
- accepts and illegal_opcode are registered and last exactly one cycle, coincident with the IDLE re-entry cycle.
- Each wait cycle on memory_ready or output_pc_ready adds one cycle; there is no combinational path from ready inputs to outputs except via state.
- Inputs current_characters and end_of_string are sampled only in EXEC.

## Test plan
- Reset mid-FETCH (pc=0x10): assert rst, then deassert.
  - Required: memory_valid=0, no output; input_pc_ready=1 one cycle after rst deasserts.
- NOT_MATCH, lo=0x41, context 2 char 0x41, pc=0x62:
  - Required: no output_pc_valid within 10 cycles; input_pc_ready=1.
  - Repeat with lo=0x42. Required: output_pc=0x63, output_cc_id=2, exactly one transfer.
- RANGE lo=0x30 hi=0x39 at pc=0x1FF:
  - Char 0x35: output_pc=0x000 (wrap).
  - Char 0x3A: no output.
  - Char 0x35 with eos=1: no output.
- SPLIT tgt=0x080 at pc=0x0A0, output_pc_ready held low for 3 cycles:
  - Required: output_pc stays 0x0A1 while stalled.
  - Then 0x080 follows, same cc_id.
  - input_pc_ready stays 0 until both transfers complete.
- ACCEPT with eos=1 on context 3: one-cycle accepts pulse, no output PC. ACCEPT with eos=0: no pulse, no output.
- Opcode 0xF: one-cycle illegal_opcode pulse, no output, input_pc_ready=1 in cycle 3. JMP tgt=0x005: output_pc=0x005.

Source files
------------

// File: rtl/regex_cpu_ext.sv
// Single-thread regex instruction executor: fetches one instruction per thread and
// emits successor PCs, an accept pulse or an illegal-opcode pulse.
module regex_cpu_ext #(
    parameter int unsigned PC_WIDTH          = 9,
    parameter int unsigned CC_ID_BITS        = 2,
    parameter int unsigned CHARACTER_WIDTH   = 8,
    parameter int unsigned MEMORY_WIDTH      = 20,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]   current_characters,
    input  logic [(2**CC_ID_BITS)-1:0]                   end_of_string,
    input  logic                                         input_pc_valid,
    output logic                                         input_pc_ready,
    input  logic [CC_ID_BITS-1:0]                        input_cc_id,
    input  logic [PC_WIDTH-1:0]                          input_pc,
    output logic                                         memory_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                 memory_addr,
    input  logic                                         memory_ready,
    input  logic [MEMORY_WIDTH-1:0]                      memory_data,
    output logic                                         output_pc_valid,
    input  logic                                         output_pc_ready,
    output logic [PC_WIDTH-1:0]                          output_pc,
    output logic [CC_ID_BITS-1:0]                        output_cc_id,
    output logic                                         accepts,
    output logic                                         illegal_opcode
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT1, OUT2} state_e;

    typedef enum logic [3:0] {
        OP_ACCEPT    = 4'd0,
        OP_SPLIT     = 4'd1,
        OP_MATCH     = 4'd2,
        OP_NOT_MATCH = 4'd3,
        OP_MATCH_ANY = 4'd4,
        OP_JMP       = 4'd5,
        OP_RANGE     = 4'd6,
        OP_NOT_RANGE = 4'd7
    } opcode_e;

    state_e                    state, state_next;
    logic [PC_WIDTH-1:0]       pc, pc_inc, tgt, exec_pc, out_pc;
    logic [CC_ID_BITS-1:0]     cc_id;
    logic [MEMORY_WIDTH-1:0]   instr;
    logic [3:0]                opcode;
    logic [CHARACTER_WIDTH-1:0] ch, lo, hi;
    logic                      eos, survive, illegal, split_q, accept_q, illegal_q;

    assign opcode  = instr[MEMORY_WIDTH-1 -: 4];
    assign lo      = instr[CHARACTER_WIDTH-1:0];
    assign hi      = instr[2*CHARACTER_WIDTH-1:CHARACTER_WIDTH];
    assign tgt     = instr[PC_WIDTH-1:0];
    assign ch      = current_characters[cc_id*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    assign eos     = end_of_string[cc_id];
    assign pc_inc  = pc + PC_WIDTH'(1);
    assign exec_pc = (opcode == OP_JMP) ? tgt : pc_inc;

    // Character ops die at end of string; SPLIT/JMP ignore eos entirely.
    always_comb begin
        survive = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_ACCEPT:    survive = 1'b0;
            OP_SPLIT:     survive = 1'b1;
            OP_JMP:       survive = 1'b1;
            OP_MATCH:     survive = !eos && (ch == lo);
            OP_NOT_MATCH: survive = !eos && (ch != lo);
            OP_MATCH_ANY: survive = !eos;
            OP_RANGE:     survive = !eos && (ch >= lo) && (ch <= hi);
            OP_NOT_RANGE: survive = !eos && ((ch < lo) || (ch > hi));
            default:      illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (input_pc_valid) state_next = FETCH;
            FETCH:   if (memory_ready) state_next = EXEC;
            EXEC:    state_next = survive ? OUT1 : IDLE;
            OUT1:    if (output_pc_ready) state_next = split_q ? OUT2 : IDLE;
            OUT2:    if (output_pc_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            cc_id     <= '0;
            instr     <= '0;
            out_pc    <= '0;
            split_q   <= 1'b0;
            accept_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            accept_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: if (input_pc_valid) begin
                    pc    <= input_pc;
                    cc_id <= input_cc_id;
                end
                FETCH: if (memory_ready) instr <= memory_data;
                EXEC: begin
                    out_pc    <= exec_pc;
                    split_q   <= (opcode == OP_SPLIT);
                    accept_q  <= (opcode == OP_ACCEPT) && eos;
                    illegal_q <= illegal;
                end
                // Second SPLIT successor is loaded only once the first has transferred.
                OUT1: if (output_pc_ready && split_q) out_pc <= tgt;
                default: ;
            endcase
        end
    end

    always_comb begin
        input_pc_ready  = !rst && (state == IDLE);
        memory_valid    = !rst && (state == FETCH);
        memory_addr     = MEMORY_ADDR_WIDTH'(pc);
        output_pc_valid = !rst && ((state == OUT1) || (state == OUT2));
        output_pc       = out_pc;
        output_cc_id    = cc_id;
        accepts         = !rst && accept_q;
        illegal_opcode  = !rst && illegal_q;
    end

endmodule

// File: tb/tb_regex_cpu_ext.sv
// Table-driven bench for regex_cpu_ext with a scoreboard queue of expected successor PCs.
module tb_regex_cpu_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_characters;
    logic [3:0]  end_of_string;
    logic        input_pc_valid, input_pc_ready;
    logic [1:0]  input_cc_id;
    logic [8:0]  input_pc;
    logic        memory_valid;
    logic [10:0] memory_addr;
    logic        memory_ready;
    logic [19:0] memory_data;
    logic        output_pc_valid, output_pc_ready;
    logic [8:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        accepts, illegal_opcode;

    int checks = 0;
    int errors = 0;

    regex_cpu_ext #(
        .PC_WIDTH(9), .CC_ID_BITS(2), .CHARACTER_WIDTH(8),
        .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11)
    ) dut (
        .clk(clk), .rst(rst),
        .current_characters(current_characters), .end_of_string(end_of_string),
        .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
        .input_cc_id(input_cc_id), .input_pc(input_pc),
        .memory_valid(memory_valid), .memory_addr(memory_addr),
        .memory_ready(memory_ready), .memory_data(memory_data),
        .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
        .output_pc(output_pc), .output_cc_id(output_cc_id),
        .accepts(accepts), .illegal_opcode(illegal_opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] operand;
        logic [8:0]  pc;
        logic [1:0]  cc;
        logic [7:0]  ch;
        logic        eos;
        int          mem_wait;
        int          out_stall;
        int          n_out;
        logic [8:0]  exp0;
        logic [8:0]  exp1;
        logic        exp_acc;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [8:0] pc;
        logic [1:0] cc;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(logic [3:0] op, logic [15:0] operand, logic [8:0] pc,
                                logic [1:0] cc, logic [7:0] ch, logic eos, int mem_wait,
                                int out_stall, int n_out, logic [8:0] exp0, logic [8:0] exp1,
                                logic exp_acc, logic exp_ill);
        vec_t v;
        v.op = op; v.operand = operand; v.pc = pc; v.cc = cc; v.ch = ch; v.eos = eos;
        v.mem_wait = mem_wait; v.out_stall = out_stall; v.n_out = n_out;
        v.exp0 = exp0; v.exp1 = exp1; v.exp_acc = exp_acc; v.exp_ill = exp_ill;
        return v;
    endfunction

    // Runs one thread starting and ending on a negedge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   stall;
        int   cyc;
        chk("idle_ready", input_pc_ready, 1);
        if (v.n_out > 0) begin e.pc = v.exp0; e.cc = v.cc; sbq.push_back(e); end
        if (v.n_out > 1) begin e.pc = v.exp1; e.cc = v.cc; sbq.push_back(e); end
        input_pc_valid = 1'b1;
        input_pc       = v.pc;
        input_cc_id    = v.cc;
        @(negedge clk);
        input_pc_valid = 1'b0;
        input_pc       = 9'($urandom);
        chk("busy_ready", input_pc_ready, 0);
        for (int w = 0; w < v.mem_wait; w++) begin
            chk("fetch_valid_wait", memory_valid, 1);
            chk("fetch_addr_wait", memory_addr, {2'b00, v.pc});
            @(negedge clk);
        end
        chk("fetch_valid", memory_valid, 1);
        chk("fetch_addr", memory_addr, {2'b00, v.pc});
        memory_ready = 1'b1;
        memory_data  = {v.op, v.operand};
        for (int k = 0; k < 4; k++) begin
            current_characters[k*8 +: 8] = (k == int'(v.cc)) ? v.ch : ~v.ch;
            end_of_string[k]             = (k == int'(v.cc)) ? v.eos : ~v.eos;
        end
        @(negedge clk);
        memory_ready = 1'b0;
        memory_data  = 20'($urandom);
        chk("exec_no_mem", memory_valid, 0);
        chk("exec_no_out", output_pc_valid, 0);
        @(negedge clk);
        current_characters = $urandom;
        end_of_string      = 4'($urandom);
        chk("c3_accepts", accepts, v.exp_acc);
        chk("c3_illegal", illegal_opcode, v.exp_ill);
        chk("c3_out_valid", output_pc_valid, v.n_out > 0);
        chk("c3_in_ready", input_pc_ready, v.n_out == 0);
        stall = v.out_stall;
        cyc   = 0;
        while (!input_pc_ready && cyc < 20) begin
            if (output_pc_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", output_pc, 9'h1ff ^ output_pc);
                    output_pc_ready = 1'b1;
                end else if (stall > 0) begin
                    chk("stall_pc", output_pc, sbq[0].pc);
                    chk("stall_cc", output_cc_id, sbq[0].cc);
                    output_pc_ready = 1'b0;
                    stall--;
                end else begin
                    e = sbq.pop_front();
                    chk("out_pc", output_pc, e.pc);
                    chk("out_cc", output_cc_id, e.cc);
                    output_pc_ready = 1'b1;
                end
            end else begin
                output_pc_ready = 1'b0;
            end
            chk("no_pulse_late", {30'd0, accepts, illegal_opcode}, 0);
            @(negedge clk);
            output_pc_ready = 1'b0;
            cyc++;
        end
        chk("thread_done", input_pc_ready, 1);
        chk("sb_empty", sbq.size(), 0);
        sbq.delete();
        chk("idle_out_valid", output_pc_valid, 0);
        @(negedge clk);
        chk("pulse_one_cycle", {30'd0, accepts, illegal_opcode}, 0);
        chk("idle_no_out", output_pc_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        current_characters = '0;
        end_of_string = '0;
        input_pc_valid = 1'b0;
        input_cc_id = '0;
        input_pc = '0;
        memory_ready = 1'b0;
        memory_data = '0;
        output_pc_ready = 1'b0;

        //        op    operand   pc     cc ch     eos mw st n  exp0    exp1  acc ill
        vecs.push_back(mk(4'h3, 16'h0041, 9'h062, 2, 8'h41, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h3, 16'h0042, 9'h062, 2, 8'h41, 0, 0, 0, 1, 9'h063, 9'h000, 0, 0));
        vecs.push_back(mk(4'h6, 16'h3930, 9'h1FF, 1, 8'h35, 0, 0, 0, 1, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h6, 16'h3930, 9'h1FF, 1, 8'h3A, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h6, 16'h3930, 9'h1FF, 1, 8'h35, 1, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h1, 16'h0080, 9'h0A0, 0, 8'h00, 0, 0, 3, 2, 9'h0A1, 9'h080, 0, 0));
        vecs.push_back(mk(4'h0, 16'h0000, 9'h040, 3, 8'h00, 1, 0, 0, 0, 9'h000, 9'h000, 1, 0));
        vecs.push_back(mk(4'h0, 16'h0000, 9'h040, 3, 8'h00, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'hF, 16'h1234, 9'h050, 1, 8'h00, 0, 0, 0, 0, 9'h000, 9'h000, 0, 1));
        vecs.push_back(mk(4'h8, 16'h0000, 9'h055, 0, 8'h00, 0, 0, 0, 0, 9'h000, 9'h000, 0, 1));
        vecs.push_back(mk(4'h5, 16'h0005, 9'h010, 0, 8'h00, 0, 0, 0, 1, 9'h005, 9'h000, 0, 0));
        vecs.push_back(mk(4'h5, 16'hFE05, 9'h011, 1, 8'h00, 1, 2, 0, 1, 9'h005, 9'h000, 0, 0));
        vecs.push_back(mk(4'h2, 16'h0061, 9'h020, 2, 8'h61, 0, 0, 0, 1, 9'h021, 9'h000, 0, 0));
        vecs.push_back(mk(4'h2, 16'h0061, 9'h020, 2, 8'h62, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h2, 16'h0061, 9'h020, 2, 8'h61, 1, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h4, 16'h0000, 9'h030, 0, 8'h00, 0, 0, 1, 1, 9'h031, 9'h000, 0, 0));
        vecs.push_back(mk(4'h4, 16'h0000, 9'h030, 0, 8'h00, 1, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h7, 16'h3930, 9'h070, 3, 8'h3A, 0, 0, 0, 1, 9'h071, 9'h000, 0, 0));
        vecs.push_back(mk(4'h7, 16'h3930, 9'h070, 3, 8'h35, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h7, 16'h3930, 9'h070, 3, 8'h2F, 0, 0, 0, 1, 9'h071, 9'h000, 0, 0));
        vecs.push_back(mk(4'h7, 16'h3930, 9'h070, 3, 8'h3A, 1, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h6, 16'h3930, 9'h070, 3, 8'h30, 0, 0, 0, 1, 9'h071, 9'h000, 0, 0));
        vecs.push_back(mk(4'h6, 16'h3930, 9'h070, 3, 8'h39, 0, 0, 0, 1, 9'h071, 9'h000, 0, 0));
        vecs.push_back(mk(4'h6, 16'h1020, 9'h070, 1, 8'h15, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0));
        vecs.push_back(mk(4'h7, 16'h1020, 9'h070, 1, 8'h15, 0, 0, 0, 1, 9'h071, 9'h000, 0, 0));
        vecs.push_back(mk(4'h1, 16'h0100, 9'h1FF, 2, 8'h00, 0, 1, 0, 2, 9'h000, 9'h100, 0, 0));
        vecs.push_back(mk(4'h1, 16'h0003, 9'h004, 1, 8'h00, 1, 0, 2, 2, 9'h005, 9'h003, 0, 0));

        repeat (3) @(negedge clk);
        chk("rst_in_ready", input_pc_ready, 0);
        chk("rst_mem_valid", memory_valid, 0);
        chk("rst_out_valid", output_pc_valid, 0);
        chk("rst_accepts", accepts, 0);
        chk("rst_illegal", illegal_opcode, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", input_pc_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while fetching, with a memory response arriving during reset.
        input_pc_valid = 1'b1;
        input_pc = 9'h010;
        input_cc_id = 2'd1;
        @(negedge clk);
        input_pc_valid = 1'b0;
        chk("mid_fetch_valid", memory_valid, 1);
        chk("mid_fetch_addr", memory_addr, 11'h010);
        rst = 1'b1;
        memory_ready = 1'b1;
        memory_data = {4'h4, 16'h0000};
        @(negedge clk);
        chk("abort_mem_valid", memory_valid, 0);
        chk("abort_out_valid", output_pc_valid, 0);
        chk("abort_ready_in_rst", input_pc_ready, 0);
        rst = 1'b0;
        memory_ready = 1'b0;
        #1;
        chk("abort_ready_after", input_pc_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_quiet", {29'd0, output_pc_valid, memory_valid, accepts | illegal_opcode}, 0);
        end

        run_vec(mk(4'h5, 16'h0005, 9'h0F0, 2, 8'h00, 0, 0, 0, 1, 9'h005, 9'h000, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
